instruction_decode_stage: RTL

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

---
 rtl/instruction_decode_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_decode_stage: 2-entry skid FIFO feeding a combinational MIPS   |
// | subset decoder. Revision: 1.0                                              |
// +----------------------------------------------------------------------------+
module instruction_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [29:0] pc_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic [29:0] pc_out,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target,
    output logic [2:0]  aluOp,
    output logic        illegal,
    output logic        regWrite,
    output logic        regDst,
    output logic        aluSrc,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        branch,
    output logic        jump,
    output logic        jumpReg
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_regimm = 6'h01;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_slt   = 6'h2A;
    localparam logic [2:0] c_alu_add  = 3'b000;
    localparam logic [2:0] c_alu_sub  = 3'b001;
    localparam logic [2:0] c_alu_and  = 3'b010;
    localparam logic [2:0] c_alu_or   = 3'b011;
    localparam logic [2:0] c_alu_slt  = 3'b100;

    // Slot 0 is always the head; slot 1 only holds data when count is 2.
    logic [1:0]  count_q, count_d;
    logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [29:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic        w_push, w_pop;
    logic [5:0]  w_opcode;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0_d = instr_in;
                        pc0_d    = pc_in;
                    end else begin
                        instr1_d = instr_in;
                        pc1_d    = pc_in;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    instr0_d = instr1_q;
                    pc0_d    = pc1_q;
                    count_d  = count_q - 2'd1;
                end
                // Only reachable at count 1: the new entry replaces the head.
                2'b11: begin
                    instr0_d = instr_in;
                    pc0_d    = pc_in;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            instr0_q <= 32'd0;
            instr1_q <= 32'd0;
            pc0_q    <= 30'd0;
            pc1_q    <= 30'd0;
        end else begin
            count_q  <= count_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
        end
    end

    assign w_opcode = instr0_q[31:26];
    assign pc_out   = pc0_q;
    assign rs       = instr0_q[25:21];
    assign rt       = instr0_q[20:16];
    assign rd       = instr0_q[15:11];
    assign shamt    = instr0_q[10:6];
    assign funct    = instr0_q[5:0];
    assign imm16    = instr0_q[15:0];
    assign target   = instr0_q[25:0];

    always_comb begin
        regWrite = 1'b0;
        regDst   = 1'b0;
        aluSrc   = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        jumpReg  = 1'b0;
        aluOp    = c_alu_add;
        illegal  = 1'b0;
        if (out_valid) begin
            case (w_opcode)
                c_op_rtype: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                    case (instr0_q[5:0])
                        c_fn_add: aluOp = c_alu_add;
                        c_fn_sub: aluOp = c_alu_sub;
                        c_fn_and: aluOp = c_alu_and;
                        c_fn_or:  aluOp = c_alu_or;
                        c_fn_slt: aluOp = c_alu_slt;
                        c_fn_jr: begin
                            regWrite = 1'b0;
                            regDst   = 1'b0;
                            jumpReg  = 1'b1;
                        end
                        default: begin
                            regWrite = 1'b0;
                            regDst   = 1'b0;
                            illegal  = 1'b1;
                        end
                    endcase
                end
                c_op_lw: begin
                    regWrite = 1'b1;
                    aluSrc   = 1'b1;
                    memRead  = 1'b1;
                    memToReg = 1'b1;
                end
                c_op_sw: begin
                    aluSrc   = 1'b1;
                    memWrite = 1'b1;
                end
                c_op_addi: begin
                    regWrite = 1'b1;
                    aluSrc   = 1'b1;
                end
                c_op_regimm: begin
                    if (instr0_q[20:16] == 5'd0) begin
                        branch = 1'b1;
                        aluOp  = c_alu_sub;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                c_op_j:  jump    = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire
